// File: rtl/k_and_s_pkg.sv
// Shared types and opcode encodings for the K&S data path.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BNNEG, I_BNZERO,
        I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
    } decoded_instruction_type;

    typedef enum logic [1:0] {
        ALU_OR  = 2'd0,
        ALU_ADD = 2'd1,
        ALU_SUB = 2'd2,
        ALU_AND = 2'd3
    } alu_op_t;

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_BRANCH = 8'h01;
    localparam logic [7:0] OP_BZERO  = 8'h02;
    localparam logic [7:0] OP_BNEG   = 8'h03;
    localparam logic [7:0] OP_BNNEG  = 8'h0A;
    localparam logic [7:0] OP_BNZERO = 8'h0B;
    localparam logic [7:0] OP_LOAD   = 8'h81;
    localparam logic [7:0] OP_STORE  = 8'h82;
    localparam logic [7:0] OP_MOVE   = 8'h91;
    localparam logic [7:0] OP_ADD    = 8'hA1;
    localparam logic [7:0] OP_SUB    = 8'hA2;
    localparam logic [7:0] OP_AND    = 8'hA3;
    localparam logic [7:0] OP_OR     = 8'hA4;
    localparam logic [7:0] OP_HALT   = 8'hFF;

endpackage

// File: rtl/ks_alu.sv
// Combinational ALU: OR/ADD/SUB/AND with zero, negative and overflow flags.
module ks_alu
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              neg,
    output logic              unsigned_overflow,
    output logic              signed_overflow
);

    logic [DATA_W:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        result            = '0;
        unsigned_overflow = 1'b0;
        signed_overflow   = 1'b0;
        unique case (op)
            ALU_OR:  result = a | b;
            ALU_ADD: begin
                result            = sum[DATA_W-1:0];
                unsigned_overflow = sum[DATA_W];
                signed_overflow   = (a[DATA_W-1] == b[DATA_W-1]) &&
                                    (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                result            = a - b;
                unsigned_overflow = (a < b);
                signed_overflow   = (a[DATA_W-1] != b[DATA_W-1]) &&
                                    (result[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND: result = a & b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[DATA_W-1];

endmodule

// File: rtl/ks_data_path_p.sv
// K&S data path: PC, IR, decoder, register file, ALU and flags register.
module ks_data_path_p
    import k_and_s_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int REG_AW = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic [1:0]              operation,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       data_out,
    input  logic [DATA_W-1:0]       data_in
);

    localparam int NREG    = 2 ** REG_AW;
    // Only the opcode and the low operand bits are ever decoded, so the IR keeps just those.
    localparam int FIELD_W = (ADDR_W + REG_AW > 3 * REG_AW) ? ADDR_W + REG_AW : 3 * REG_AW;

    logic [7:0]         ir_op;
    logic [FIELD_W-1:0] ir_field;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  mem_addr;
    logic [REG_AW-1:0]  a_addr, b_addr, c_addr;
    logic [DATA_W-1:0]  regs [NREG];
    logic [DATA_W-1:0]  bus_a, bus_b, bus_c, alu_result;
    logic               alu_zero, alu_neg, alu_uov, alu_sov;

    always_comb begin
        decoded_instruction = I_NOP;
        unique case (ir_op)
            OP_BRANCH: decoded_instruction = I_BRANCH;
            OP_BZERO:  decoded_instruction = I_BZERO;
            OP_BNEG:   decoded_instruction = I_BNEG;
            OP_BNNEG:  decoded_instruction = I_BNNEG;
            OP_BNZERO: decoded_instruction = I_BNZERO;
            OP_LOAD:   decoded_instruction = I_LOAD;
            OP_STORE:  decoded_instruction = I_STORE;
            OP_MOVE:   decoded_instruction = I_MOVE;
            OP_ADD:    decoded_instruction = I_ADD;
            OP_SUB:    decoded_instruction = I_SUB;
            OP_AND:    decoded_instruction = I_AND;
            OP_OR:     decoded_instruction = I_OR;
            OP_HALT:   decoded_instruction = I_HALT;
            default:   decoded_instruction = I_NOP;
        endcase
    end

    always_comb begin
        a_addr   = '0;
        b_addr   = '0;
        c_addr   = '0;
        mem_addr = '0;
        unique case (decoded_instruction)
            I_LOAD: begin
                c_addr   = ir_field[ADDR_W +: REG_AW];
                mem_addr = ir_field[ADDR_W-1:0];
            end
            I_STORE: begin
                a_addr   = ir_field[ADDR_W +: REG_AW];
                mem_addr = ir_field[ADDR_W-1:0];
            end
            I_BRANCH, I_BZERO, I_BNEG, I_BNNEG, I_BNZERO: begin
                mem_addr = ir_field[ADDR_W-1:0];
            end
            I_MOVE: begin
                a_addr = ir_field[0 +: REG_AW];
                b_addr = ir_field[0 +: REG_AW];
                c_addr = ir_field[REG_AW +: REG_AW];
            end
            I_ADD, I_SUB, I_AND, I_OR: begin
                a_addr = ir_field[0 +: REG_AW];
                b_addr = ir_field[REG_AW +: REG_AW];
                c_addr = ir_field[2*REG_AW +: REG_AW];
            end
            default: begin
                a_addr = '0;
            end
        endcase
    end

    assign bus_a    = regs[a_addr];
    assign bus_b    = regs[b_addr];
    assign bus_c    = c_sel ? data_in : alu_result;
    assign data_out = bus_a;
    assign ram_addr = addr_sel ? pc : mem_addr;

    ks_alu #(.DATA_W(DATA_W)) u_alu (
        .a                 (bus_a),
        .b                 (bus_b),
        .op                (alu_op_t'(operation)),
        .result            (alu_result),
        .zero              (alu_zero),
        .neg               (alu_neg),
        .unsigned_overflow (alu_uov),
        .signed_overflow   (alu_sov)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_op    <= '0;
            ir_field <= '0;
        end else if (ir_enable) begin
            ir_op    <= data_in[DATA_W-1 -: 8];
            ir_field <= data_in[FIELD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (pc_enable) begin
            pc <= branch ? mem_addr : pc + ADDR_W'(1);
        end
    end

    // c_addr comes from the IR held before this edge, so a simultaneous IR load cannot redirect the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (write_reg_enable) begin
            regs[c_addr] <= bus_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= alu_zero;
            neg_op            <= alu_neg;
            unsigned_overflow <= alu_uov;
            signed_overflow   <= alu_sov;
        end
    end

endmodule

// File: doc/ks_data_path_p.md
# ks_data_path_p

Parametrised successor to the K&S processor data path. Holds the program counter, instruction register, instruction decoder, an N-entry register file, the ALU with overflow detection and a persistent flags register. It sits between the K&S control unit, which drives all enables and selects, and the single-port program/data RAM. Data width, RAM address width and register count are configurable; default parameters reproduce the 16-bit / 32-word / 4-register machine.

## Interface
- DATA_W, 16: data, register and instruction width; must be ≥ 16.
- ADDR_W, 5: RAM address and PC width; requires ADDR_W + REG_AW ≤ DATA_W − 8.
- REG_AW, 2: register index width, giving NREG = 2**REG_AW registers; requires 3·REG_AW ≤ DATA_W − 8.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- branch  in  1  when `pc_enable` is high: 1 loads the PC from the decoded address, 0 increments the PC.
- pc_enable  in  1  PC update enable.
- ir_enable  in  1  loads `data_in` into the IR.
- addr_sel  in  1  selects `ram_addr`: 1 = PC, 0 = decoded memory address.
- c_sel  in  1  selects `bus_c`: 1 = `data_in`, 0 = ALU result.
- operation  in  2  ALU operation: 00 OR, 01 ADD, 10 SUB, 11 AND.
- write_reg_enable  in  1  writes `bus_c` into register `c_addr`.
- flags_reg_enable  in  1  captures the ALU flags into the flags register.
- decoded_instruction  out  decoded_instruction_type  current instruction.
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  flags register outputs.
- ram_addr  out  ADDR_W  RAM address.
- data_out  out  DATA_W  RAM write data; equals register `a_addr`.
- data_in  in  DATA_W  RAM read data.

## Operation
- Opcode is `IR[DATA_W-1:DATA_W-8]`:
  - 0x00 NOP; 0x01 BRANCH; 0x02 BZERO; 0x03 BNEG; 0x0A BNNEG; 0x0B BNZERO.
  - 0x81 LOAD; 0x82 STORE; 0x91 MOVE.
  - 0xA1 ADD; 0xA2 SUB; 0xA3 AND; 0xA4 OR; 0xFF HALT.
  - Any other opcode decodes as I_NOP.
- Field extraction, with R = REG_AW:
  - LOAD: `c_addr = IR[ADDR_W+R-1:ADDR_W]`, `mem_addr = IR[ADDR_W-1:0]`.
  - STORE: `a_addr` from the same register field; `mem_addr` as LOAD.
  - Branch opcodes: `mem_addr = IR[ADDR_W-1:0]`.
  - MOVE: `a_addr = b_addr = IR[R-1:0]`, `c_addr = IR[2R-1:R]`. The control unit issues OR, so the result equals the source register.
  - ADD/SUB/AND/OR: `a_addr = IR[R-1:0]`, `b_addr = IR[2R-1:R]`, `c_addr = IR[3R-1:2R]`.
  - Fields not used by the current opcode are driven to 0. The decoder is fully combinational with no latches.
- Register file:
  - `bus_a = reg[a_addr]`, `bus_b = reg[b_addr]`, both combinational.
  - One write port at `c_addr`. Registers are never written from `bus_a` or `bus_b`.
- ALU, all arithmetic modulo 2**DATA_W:
  - zero = (result == 0); neg = result MSB.
  - ADD: unsigned overflow = carry out; signed overflow = operands share a sign and the result sign differs.
  - SUB: unsigned overflow = borrow (a < b unsigned); signed overflow = operand signs differ and the result sign differs from a.
  - AND/OR: both overflow flags are 0.
- PC:
  - Increments modulo 2**ADDR_W; 2**ADDR_W−1 wraps to 0.
  - When `branch` is high, loads `mem_addr`.
- Flags register holds its value while `flags_reg_enable` is low; it is not cleared.

## Timing
- Reset (asynchronous, takes effect immediately): PC, IR, all registers and all flags = 0.
  - Because IR = 0, `decoded_instruction` = I_NOP, `data_out` = 0 and `ram_addr` = 0 during reset.
- One edge of latency: IR, PC, register writes and flags all update on the same rising edge in which their enable is sampled high.
- `decoded_instruction`, `ram_addr`, `data_out` and the ALU result are combinational from registered state and inputs.
- `ir_enable` and `write_reg_enable` high in the same cycle: the write uses the `c_addr` decoded from the old IR.
- A register read in the cycle it is written returns the old value; there is no bypass.
- Reset asserted mid-instruction discards all state. No partial write may survive.

## Structure
- k_and_s_pkg contains:
  - `decoded_instruction_type`;
  - the 8-bit opcode localparams;
  - an `alu_op_t` enum (OR/ADD/SUB/AND = 0..3).
- Sub-module ks_alu: parametrised by DATA_W; purely combinational result and the four flag outputs.
- All sequential state lives in ks_data_path_p.

## Test plan
- Reset mid-run with non-zero PC/registers → all outputs 0 and `decoded_instruction` = I_NOP immediately, before any clock edge.
- LOAD 0x8145 with `data_in` = 0x1234, `c_sel` = 1, write enabled → r2 = 0x1234 next edge; with `addr_sel` = 0, `ram_addr` = 5.
- ADD r3 = r0 + r1 with 0x7FFF + 0x0001 → 0x8000, neg = 1, signed_ovf = 1, unsigned_ovf = 0. With 0xFFFF + 0x0001 → 0, zero = 1, unsigned_ovf = 1.
- SUB with 0x0000 − 0x0001 → 0xFFFF, unsigned_ovf = 1, neg = 1. Then `flags_reg_enable` = 0 for 3 cycles → flags unchanged.
- PC at 31 with `pc_enable` = 1, `branch` = 0 → 0. BRANCH 0x0107 with `branch` = 1 → PC = 7.
- DATA_W = 32, ADDR_W = 8, REG_AW = 3 build: ADD with fields a = 5, b = 6, c = 7 → r7 = r5 + r6; unknown opcode 0x55 → I_NOP.
